branch_update_unit: RTL

- Write-side companion of the fetch-stage prediction cache. Takes resolved branch outcomes from execute, together with the prediction info fetch carried down the pipe.
- Computes the next 2-bit counter state and target, and generates mispredict flush/redirect.
- Buffers cache writes in a small FIFO and drains them into the prediction cache write port (WE/WAddr/Data/Instr_new_CB).

---
 rtl/branch_update_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/branch_update_unit.sv
// rtl/branch_update_unit.sv - resolved-branch counter/target update, mispredict flush and cache write FIFO
// Optional write filtering for saturated, correctly predicted hits: define UPDATE_FILTER_EN.
module branch_update_unit #(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ResValid,
    output logic        ResReady,
    input  logic [31:0] ResPC,
    input  logic        ResTaken,
    input  logic [31:0] ResTarget,
    input  logic        PredHit,
    input  logic        PredSrc,
    input  logic [1:0]  PredCB,
    input  logic [31:0] PredPPC,
    input  logic        WrHold,
    output logic        WE,
    output logic [31:0] WAddr,
    output logic [31:0] Data,
    output logic [1:0]  Instr_new_CB,
    output logic        Flush,
    output logic [31:0] RedirectPC
);

    logic [31:0]     mem_pc_q  [DEPTH];
    logic [31:0]     mem_pc_d  [DEPTH];
    logic [31:0]     mem_tgt_q [DEPTH];
    logic [31:0]     mem_tgt_d [DEPTH];
    logic [1:0]      mem_cb_q  [DEPTH];
    logic [1:0]      mem_cb_d  [DEPTH];

    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTRW:0]   count_q, count_d;

    logic            we_q, we_d;
    logic [31:0]     waddr_q, waddr_d;
    logic [31:0]     data_q, data_d;
    logic [1:0]      cb_q, cb_d;
    logic            flush_q, flush_d;
    logic [31:0]     redirect_q, redirect_d;

    logic            full;
    logic            accept;
    logic            push;
    logic            pop;

    logic            fwd_hit;
    logic [1:0]      fwd_cb;
    logic [31:0]     fwd_tgt;
    logic [PTRW-1:0] scan_idx;

    logic            base_hit;
    logic [1:0]      base_cb;
    logic [31:0]     base_tgt;
    logic [1:0]      new_cb;
    logic [31:0]     new_tgt;
    logic            enqueue;
    logic            mispredict;

    assign full     = (count_q == (PTRW+1)'(DEPTH));
    assign ResReady = !full && !Rst;
    assign accept   = ResValid && ResReady;
    assign pop      = (count_q != '0) && !WrHold && !Rst;
    assign push     = accept && enqueue;

    // Newest-first scan: iterate oldest to newest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_cb   = 2'b00;
        fwd_tgt  = 32'd0;
        scan_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            scan_idx = wr_ptr_q - PTRW'(i + 1);
            if (((PTRW+1)'(i) < count_q) && (mem_pc_q[scan_idx] == ResPC)) begin
                fwd_hit = 1'b1;
                fwd_cb  = mem_cb_q[scan_idx];
                fwd_tgt = mem_tgt_q[scan_idx];
            end
        end
    end

    always_comb begin
        base_hit = fwd_hit ? 1'b1    : PredHit;
        base_cb  = fwd_hit ? fwd_cb  : PredCB;
        base_tgt = fwd_hit ? fwd_tgt : PredPPC;

        new_cb = 2'b10;
        if (base_hit) begin
            if (ResTaken) begin
                new_cb = (base_cb == 2'b11) ? 2'b11 : base_cb + 2'b01;
            end else begin
                new_cb = (base_cb == 2'b00) ? 2'b00 : base_cb - 2'b01;
            end
        end
        new_tgt = ResTaken ? ResTarget : base_tgt;

`ifdef UPDATE_FILTER_EN
        enqueue = base_hit ? !((new_cb == base_cb) && (new_tgt == base_tgt)) : ResTaken;
`else
        enqueue = base_hit || ResTaken;
`endif

        mispredict = (PredSrc != ResTaken) ||
                     (PredSrc && ResTaken && (PredPPC != ResTarget));
    end

    always_comb begin
        mem_pc_d  = mem_pc_q;
        mem_tgt_d = mem_tgt_q;
        mem_cb_d  = mem_cb_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        if (push) begin
            mem_pc_d[wr_ptr_q]  = ResPC;
            mem_tgt_d[wr_ptr_q] = new_tgt;
            mem_cb_d[wr_ptr_q]  = new_cb;
            wr_ptr_d            = wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PTRW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTRW+1)'(1);
        end

        // Write-port fields hold their last value when nothing retires.
        we_d    = pop;
        waddr_d = waddr_q;
        data_d  = data_q;
        cb_d    = cb_q;
        if (pop) begin
            waddr_d = mem_pc_q[rd_ptr_q];
            data_d  = mem_tgt_q[rd_ptr_q];
            cb_d    = mem_cb_q[rd_ptr_q];
        end

        flush_d    = accept && mispredict;
        redirect_d = redirect_q;
        if (accept && mispredict) begin
            redirect_d = ResTaken ? ResTarget : ResPC + 32'd4;
        end
    end

    always_ff @(posedge Clk) begin
        mem_pc_q  <= mem_pc_d;
        mem_tgt_q <= mem_tgt_d;
        mem_cb_q  <= mem_cb_d;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            waddr_q    <= 32'd0;
            data_q     <= 32'd0;
            cb_q       <= 2'b00;
            flush_q    <= 1'b0;
            redirect_q <= 32'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            data_q     <= data_d;
            cb_q       <= cb_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
        end
    end

    assign WE           = we_q;
    assign WAddr        = waddr_q;
    assign Data         = data_q;
    assign Instr_new_CB = cb_q;
    assign Flush        = flush_q;
    assign RedirectPC   = redirect_q;

endmodule
